// File: rtl/lcd_text_frame.sv
// Character frame buffer for the front-panel HD44780 LCD driver.
// Holds the current screen text and keypad digit entry, and rebuilds the frame one byte per clock after any change.
module lcd_text_frame #(
    parameter int LINES          = 2,
    parameter int CHARS_PER_LINE = 16,
    parameter int DIGITS         = 10,
    parameter int ADDR_W         = 5,
    parameter int CNT_W          = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [7:0]            rd_data,
    output logic                  busy,
    output logic                  frame_ready,
    output logic [4*DIGITS-1:0]   digits,
    output logic [CNT_W-1:0]      digit_count,
    output logic                  entry_full
);

    localparam int N     = LINES * CHARS_PER_LINE;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int COL_W = $clog2(CHARS_PER_LINE) + 1;
    localparam int LN_W  = $clog2(LINES);

    localparam logic [127:0] TXT_WELCOME0 = "    Welcome!    ";
    localparam logic [127:0] TXT_WELCOME1 = " Enter R. No. : ";
    localparam logic [127:0] TXT_ENTRY0   = "Registration No.";
    localparam logic [127:0] TXT_VALID0   = "  Valid Number  ";
    localparam logic [127:0] TXT_INVALID0 = " Invalid Number ";
    localparam logic [127:0] TXT_BLANK    = "                ";

    typedef enum logic [1:0] {WELCOME, ENTRY, VALID, INVALID} mode_t;
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    state_t              state, state_nxt;
    mode_t               mode_q;
    logic                pending;
    logic                start_fill;
    logic [ADDR_W-1:0]   idx;
    logic [COL_W-1:0]    col;
    logic [LN_W-1:0]     line;
    logic [7:0]          frame [DEPTH];
    logic [7:0]          wr_char;
    logic [4*DIGITS-1:0] digits_nxt;
    logic [CNT_W-1:0]    count_nxt;
    logic                key_accept;
    logic                mode_change;
    logic                last;

    assign entry_full  = (digit_count == CNT_W'(DIGITS));
    assign mode_change = (mode != mode_q);
    assign last        = (idx == ADDR_W'(N - 1));

    // Digit-entry register update; keys only count on the ENTRY screen.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        digits_nxt = digits;
        count_nxt  = digit_count;
        key_accept = 1'b0;
        if (mode_change && mode == WELCOME) begin
            digits_nxt = '1;
            count_nxt  = '0;
        end
        if (key_valid && mode == ENTRY) begin
            if (key_code <= 4'd9) begin
                if (!entry_full) begin
                    for (int i = 0; i < DIGITS; i++)
                        if (digit_count == CNT_W'(i)) digits_nxt[4*i +: 4] = key_code;
                    count_nxt  = digit_count + CNT_W'(1);
                    key_accept = 1'b1;
                end
            end else if (key_code == 4'hA) begin
                if (digit_count != '0) begin
                    for (int i = 0; i < DIGITS; i++)
                        if (digit_count == CNT_W'(i + 1)) digits_nxt[4*i +: 4] = 4'hF;
                    count_nxt  = digit_count - CNT_W'(1);
                    key_accept = 1'b1;
                end
            end else if (key_code == 4'hB) begin
                digits_nxt = '1;
                count_nxt  = '0;
                key_accept = 1'b1;
            end
        end
    end

    // Character for the byte the sequencer is writing this cycle.
    always_comb begin
        logic [127:0] txt;
        logic [3:0]   nib;
        txt     = TXT_BLANK;
        nib     = 4'hF;
        wr_char = 8'h20;
        if (line == '0) begin
            case (mode_q)
                WELCOME: txt = TXT_WELCOME0;
                ENTRY:   txt = TXT_ENTRY0;
                VALID:   txt = TXT_VALID0;
                default: txt = TXT_INVALID0;
            endcase
        end else if (line == LN_W'(1) && mode_q == WELCOME) begin
            txt = TXT_WELCOME1;
        end
        if (col < COL_W'(16)) wr_char = txt[{~col[3:0], 3'b000} +: 8];
        if (line == LN_W'(1) && mode_q == ENTRY && col < COL_W'(DIGITS)) begin
            for (int i = 0; i < DIGITS; i++)
                if (col == COL_W'(i)) nib = digits[4*i +: 4];
            if (nib <= 4'd9)       wr_char = 8'h30 + {4'h0, nib};
            else if (nib == 4'hF)  wr_char = 8'h5F;
            else                   wr_char = 8'h3F;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_fill  = 1'b0;
        busy        = 1'b0;
        frame_ready = 1'b0;
        case (state)
            S_IDLE: begin
                if (pending) begin
                    start_fill = 1'b1;
                    state_nxt  = S_FILL;
                end
            end
            S_FILL: begin
                busy = 1'b1;
                if (last) state_nxt = S_DONE;
            end
            S_DONE: begin
                // A trigger seen here means the frame just written is already stale.
                if (pending) begin
                    start_fill = 1'b1;
                    state_nxt  = S_FILL;
                end else begin
                    frame_ready = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            mode_q      <= WELCOME;
            pending     <= 1'b1;
            digits      <= '1;
            digit_count <= '0;
            idx         <= '0;
            col         <= '0;
            line        <= '0;
        end else begin
            state       <= state_nxt;
            digits      <= digits_nxt;
            digit_count <= count_nxt;
            if (mode_change) mode_q <= mode_t'(mode);
            pending <= key_accept | mode_change | (pending & ~start_fill);
            if (start_fill) begin
                idx  <= '0;
                col  <= '0;
                line <= '0;
            end else if (state == S_FILL) begin
                idx <= idx + ADDR_W'(1);
                if (col == COL_W'(CHARS_PER_LINE - 1)) begin
                    col  <= '0;
                    line <= line + LN_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

    // NOTE: the frame store is reset because the panel must show blanks straight out of reset;
    // entries at or above N are never written and stay blank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) frame[i] <= 8'h20;
            rd_data <= 8'h20;
        end else begin
            rd_data <= frame[rd_addr];
            if (state == S_FILL) frame[idx] <= wr_char;
        end
    end

endmodule
